mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 104 ++++++++++
 tb/tb_mem_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: word-addressed data memory with WB->MEM store-data forwarding
//
// Purpose:
//   Performs lw/sw data memory access for the instruction in MEM and registers
//   pc, instruction, load data and ALU result into the WB stage.
//   Optional macro MEM_STORE_DISPLAY_EN: prints one line per committed store
//   (simulation only). Without it the module contains no display statements.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   MEM_pc        in   [31:0] pc of the instruction in MEM
//   MEM_instr     in   [31:0] instruction in MEM
//   MEM_alu_data  in   [31:0] ALU result / effective byte address
//   MEM_rt_data   in   [31:0] rt value captured in EX (store data)
//   WB_we_fw      in   write enable of the instruction in WB
//   WB_addr_fw    in   [4:0] destination register of the instruction in WB
//   WB_data_fw    in   [31:0] write data of the instruction in WB
//   WB_pc         out  [31:0] registered pc
//   WB_instr      out  [31:0] registered instruction
//   WB_lw_data    out  [31:0] registered load data
//   WB_alu_data   out  [31:0] registered ALU result

module mem_stage #(
  parameter int DM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_instr,
  input  logic [31:0] MEM_alu_data,
  input  logic [31:0] MEM_rt_data,
  input  logic        WB_we_fw,
  input  logic [4:0]  WB_addr_fw,
  input  logic [31:0] WB_data_fw,
  output logic [31:0] WB_pc,
  output logic [31:0] WB_instr,
  output logic [31:0] WB_lw_data,
  output logic [31:0] WB_alu_data
);

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam int         DEPTH = 2 ** DM_AW;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      wb_pc_q, wb_instr_q, wb_lw_data_q, wb_alu_data_q;

  logic [DM_AW-1:0] word_idx;
  logic [4:0]       rt_addr;
  logic             is_sw;
  logic             fwd_hit;
  logic [31:0]      store_data_d;
  logic [31:0]      rd_data;

  // Byte address bits [1:0] and everything above the memory depth are
  // dropped, so addresses wrap around the memory.
  assign word_idx = MEM_alu_data[DM_AW+1:2];
  assign rt_addr  = MEM_instr[20:16];
  assign is_sw    = (MEM_instr[31:26] == OP_SW);

  // A store whose rt is being written by the instruction in WB takes the
  // WB value; $0 is never forwarded because it is hardwired to zero.
  assign fwd_hit      = WB_we_fw && (WB_addr_fw != 5'd0) && (WB_addr_fw == rt_addr);
  assign store_data_d = fwd_hit ? WB_data_fw : MEM_rt_data;

  // Combinational read; the value registered into WB is the pre-write word
  // when a store hits the same edge.
  assign rd_data = mem_q[word_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_pc_q       <= '0;
      wb_instr_q    <= '0;
      wb_lw_data_q  <= '0;
      wb_alu_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wb_pc_q       <= MEM_pc;
      wb_instr_q    <= MEM_instr;
      wb_lw_data_q  <= rd_data;
      wb_alu_data_q <= MEM_alu_data;
      if (is_sw) begin
        mem_q[word_idx] <= store_data_d;
      end
    end
  end

  assign WB_pc       = wb_pc_q;
  assign WB_instr    = wb_instr_q;
  assign WB_lw_data  = wb_lw_data_q;
  assign WB_alu_data = wb_alu_data_q;

`ifdef MEM_STORE_DISPLAY_EN
  always @(posedge clk) begin
    if (rst && is_sw) begin
      $display("@%h: *%h <= %h", MEM_pc, {MEM_alu_data[31:2], 2'b00}, store_data_d);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage

module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] MEM_pc, MEM_instr, MEM_alu_data, MEM_rt_data;
  logic        WB_we_fw;
  logic [4:0]  WB_addr_fw;
  logic [31:0] WB_data_fw;
  logic [31:0] WB_pc, WB_instr, WB_lw_data, WB_alu_data;

  int errors = 0;
  int checks = 0;

  mem_stage #(.DM_AW(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_pc       (MEM_pc),
    .MEM_instr    (MEM_instr),
    .MEM_alu_data (MEM_alu_data),
    .MEM_rt_data  (MEM_rt_data),
    .WB_we_fw     (WB_we_fw),
    .WB_addr_fw   (WB_addr_fw),
    .WB_data_fw   (WB_data_fw),
    .WB_pc        (WB_pc),
    .WB_instr     (WB_instr),
    .WB_lw_data   (WB_lw_data),
    .WB_alu_data  (WB_alu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lw_i(input logic [4:0] rt);
    return {6'b100011, 5'd29, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] sw_i(input logic [4:0] rt);
    return {6'b101011, 5'd29, rt, 16'h0000};
  endfunction

  localparam logic [31:0] ADD_I = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] rtd);
    MEM_pc       = pc;
    MEM_instr    = instr;
    MEM_alu_data = alu;
    MEM_rt_data  = rtd;
  endtask

  task automatic fwd(input logic we, input logic [4:0] addr, input logic [31:0] data);
    WB_we_fw   = we;
    WB_addr_fw = addr;
    WB_data_fw = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(32'h0000_0400, sw_i(5'd8), 32'h0000_0010, 32'h1111_1111);
    fwd(1'b0, 5'd0, 32'h0);
    #2;
    chk("reset_pc",    WB_pc,       32'h0);
    chk("reset_instr", WB_instr,    32'h0);
    chk("reset_lw",    WB_lw_data,  32'h0);
    chk("reset_alu",   WB_alu_data, 32'h0);
    tick();
    chk("reset_held_pc", WB_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // sw $8 -> word 4; lw reads it back next cycle
    drive(32'h0000_1000, sw_i(5'd8), 32'h0000_0010, 32'h1234_5678);
    tick();
    chk("sw_pc",        WB_pc,       32'h0000_1000);
    chk("sw_instr",     WB_instr,    sw_i(5'd8));
    chk("sw_alu",       WB_alu_data, 32'h0000_0010);
    chk("sw_pre_write", WB_lw_data,  32'h0);
    drive(32'h0000_1004, lw_i(5'd10), 32'h0000_0010, 32'h0);
    tick();
    chk("lw_after_sw", WB_lw_data, 32'h1234_5678);

    // forwarded store data overrides MEM_rt_data
    drive(32'h0000_1008, sw_i(5'd9), 32'h0000_0010, 32'h0);
    fwd(1'b1, 5'd9, 32'hCAFE_BABE);
    tick();
    chk("fwd_pre_write", WB_lw_data, 32'h1234_5678);
    fwd(1'b0, 5'd0, 32'h0);
    drive(32'h0000_100C, lw_i(5'd10), 32'h0000_0010, 32'h0);
    tick();
    chk("fwd_store", WB_lw_data, 32'hCAFE_BABE);

    // register mismatch: no forwarding
    drive(32'h0000_1010, sw_i(5'd9), 32'h0000_0014, 32'h0BAD_F00D);
    fwd(1'b1, 5'd8, 32'hDEAD_BEEF);
    tick();
    // matching register but write enable low: no forwarding
    drive(32'h0000_1014, sw_i(5'd9), 32'h0000_0018, 32'h5555_AAAA);
    fwd(1'b0, 5'd9, 32'hDEAD_BEEF);
    tick();
    fwd(1'b0, 5'd0, 32'h0);
    drive(32'h0000_1018, lw_i(5'd10), 32'h0000_0014, 32'h0);
    tick();
    chk("fwd_addr_miss", WB_lw_data, 32'h0BAD_F00D);
    drive(32'h0000_101C, lw_i(5'd10), 32'h0000_0018, 32'h0);
    tick();
    chk("fwd_we_low", WB_lw_data, 32'h5555_AAAA);

    // $0 is never forwarded
    drive(32'h0000_1020, sw_i(5'd0), 32'h0000_0020, 32'h0);
    fwd(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    fwd(1'b0, 5'd0, 32'h0);
    drive(32'h0000_1024, lw_i(5'd10), 32'h0000_0020, 32'h0);
    tick();
    chk("r0_no_fwd", WB_lw_data, 32'h0);

    // wrap-around and ignored low address bits
    drive(32'h0000_1028, sw_i(5'd8), 32'h0000_1000, 32'h0000_00AA);
    tick();
    drive(32'h0000_102C, lw_i(5'd10), 32'h0000_0000, 32'h0);
    tick();
    chk("wrap_lw0", WB_lw_data, 32'h0000_00AA);
    drive(32'h0000_1030, lw_i(5'd10), 32'h0000_0003, 32'h0);
    tick();
    chk("low_bits_lw3", WB_lw_data, 32'h0000_00AA);

    // non-memory instruction passes through and writes nothing
    drive(32'h0000_1034, ADD_I, 32'h0000_0007, 32'h7777_7777);
    tick();
    chk("add_alu",   WB_alu_data, 32'h0000_0007);
    chk("add_instr", WB_instr,    ADD_I);
    chk("add_pc",    WB_pc,       32'h0000_1034);
    drive(32'h0000_1038, lw_i(5'd10), 32'h0000_0004, 32'h0);
    tick();
    chk("add_no_write", WB_lw_data, 32'h0);
    drive(32'h0000_103C, lw_i(5'd10), 32'h0000_0010, 32'h0);
    tick();
    chk("mem_kept", WB_lw_data, 32'hCAFE_BABE);

    // mid-run reset: outputs clear immediately, pending sw discarded
    drive(32'h0000_1040, sw_i(5'd8), 32'h0000_0030, 32'h5555_5555);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_pc",    WB_pc,       32'h0);
    chk("midrst_instr", WB_instr,    32'h0);
    chk("midrst_lw",    WB_lw_data,  32'h0);
    chk("midrst_alu",   WB_alu_data, 32'h0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0000_1044, lw_i(5'd10), 32'h0000_0030, 32'h0);
    tick();
    chk("rst_sw_discard", WB_lw_data, 32'h0);
    drive(32'h0000_1048, lw_i(5'd10), 32'h0000_0010, 32'h0);
    tick();
    chk("rst_clear_w4", WB_lw_data, 32'h0);
    drive(32'h0000_104C, lw_i(5'd10), 32'h0000_0000, 32'h0);
    tick();
    chk("rst_clear_w0", WB_lw_data, 32'h0);
    chk("post_rst_pc",  WB_pc,      32'h0000_104C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
